// File: rtl/onchip_arb_pkg.sv
// Shared widths and command payload for the on-chip RAM arbiter.
package onchip_arb_pkg;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned DEPTH  = 5120;

    typedef logic [0:0] port_id_t;

    typedef struct packed {
        logic              valid;
        logic              write;
        port_id_t          owner;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/onchip_arb_pick.sv
// Two-way request picker. ONCHIP_ARB_RR_EN selects round-robin tie-breaking;
// without it port 0 has fixed priority and no pointer logic is built.
module onchip_arb_pick
    import onchip_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last,
    output logic [1:0] grant,
    output port_id_t   next_ptr
);

`ifdef ONCHIP_ARB_RR_EN
    // On a tie the port that did not win last time goes first
    always_comb begin
        grant    = req;
        next_ptr = last;
        if (req == 2'b11) begin
            grant = (last == 1'b0) ? 2'b10 : 2'b01;
        end
        if (grant[1]) begin
            next_ptr = 1'b1;
        end else if (grant[0]) begin
            next_ptr = 1'b0;
        end
    end
`else
    logic unused_last;
    assign unused_last = last[0];

    always_comb begin
        grant    = {req[1] & ~req[0], req[0]};
        next_ptr = '0;
    end
`endif

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Two-port Avalon-MM arbiter in front of the single-port on-chip RAM (1-cycle read latency).
// Define ONCHIP_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module onchip_memory_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = onchip_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W = onchip_arb_pkg::DATA_W,
    parameter int unsigned DEPTH  = onchip_arb_pkg::DEPTH
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                stall,

    input  logic                p0_chipselect,
    input  logic                p0_write,
    input  logic [ADDR_W-1:0]   p0_address,
    input  logic [DATA_W/8-1:0] p0_byteenable,
    input  logic [DATA_W-1:0]   p0_writedata,
    output logic                p0_waitrequest,
    output logic [DATA_W-1:0]   p0_readdata,
    output logic                p0_readdatavalid,
    output logic                p0_error,

    input  logic                p1_chipselect,
    input  logic                p1_write,
    input  logic [ADDR_W-1:0]   p1_address,
    input  logic [DATA_W/8-1:0] p1_byteenable,
    input  logic [DATA_W-1:0]   p1_writedata,
    output logic                p1_waitrequest,
    output logic [DATA_W-1:0]   p1_readdata,
    output logic                p1_readdatavalid,
    output logic                p1_error,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int unsigned BE_W = DATA_W / 8;

    cmd_t              cmd_q;
    cmd_t              cmd_nxt;
    logic              tag_valid_q;
    port_id_t          tag_owner_q;
    port_id_t          last_q;
    port_id_t          last_nxt;
    logic [1:0]        err_q;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic [1:0]        accept;
    logic [1:0]        rdv;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;

    assign req = {p1_chipselect, p0_chipselect};

    onchip_arb_pick u_pick (
        .req      (req),
        .last     (last_q),
        .grant    (grant),
        .next_ptr (last_nxt)
    );

    // Nothing is accepted while the pipeline is frozen or held in reset
    assign accept = grant & {2{~stall & reset_n}};

    assign p0_waitrequest = ~accept[0];
    assign p1_waitrequest = ~accept[1];

    always_comb begin
        sel_write = p0_write;
        sel_addr  = p0_address;
        sel_be    = p0_byteenable;
        sel_wdata = p0_writedata;
        if (accept[1]) begin
            sel_write = p1_write;
            sel_addr  = p1_address;
            sel_be    = p1_byteenable;
            sel_wdata = p1_writedata;
        end
        sel_in_range = (32'(sel_addr) < DEPTH);

        cmd_nxt       = '0;
        cmd_nxt.valid = (|accept) & sel_in_range;
        cmd_nxt.write = sel_write;
        cmd_nxt.owner = port_id_t'(accept[1]);
        cmd_nxt.addr  = sel_addr;
        cmd_nxt.be    = sel_be;
        cmd_nxt.wdata = sel_wdata;
    end

    // Command register, return tag and pointer all freeze together under stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q       <= '0;
            tag_valid_q <= 1'b0;
            tag_owner_q <= '0;
            last_q      <= '0;
            err_q       <= '0;
        end else begin
            err_q <= accept & {2{~sel_in_range}};
            if (!stall) begin
                cmd_q       <= cmd_nxt;
                tag_valid_q <= cmd_q.valid & ~cmd_q.write;
                tag_owner_q <= cmd_q.owner;
                last_q      <= last_nxt;
            end
        end
    end

    assign mem_address    = cmd_q.addr;
    assign mem_byteenable = cmd_q.be;
    assign mem_writedata  = cmd_q.wdata;
    assign mem_chipselect = cmd_q.valid;
    assign mem_write      = cmd_q.valid & cmd_q.write;
    assign mem_clken      = ~stall & reset_n;

    // RAM q is unregistered and held by clken, so the strobe just waits out the stall
    assign rdv[0] = tag_valid_q & ~stall & (tag_owner_q == 1'b0);
    assign rdv[1] = tag_valid_q & ~stall & (tag_owner_q == 1'b1);

    assign p0_readdatavalid = rdv[0];
    assign p1_readdatavalid = rdv[1];
    assign p0_readdata      = rdv[0] ? mem_readdata : '0;
    assign p1_readdata      = rdv[1] ? mem_readdata : '0;
    assign p0_error         = err_q[0];
    assign p1_error         = err_q[1];

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Self-checking bench for onchip_memory_arbiter with a behavioural RAM and a read scoreboard.
module tb_onchip_memory_arbiter;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned DEPTH  = 5120;
`ifdef ONCHIP_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk;
    logic              reset_n;
    logic              stall;
    logic              p0_chipselect, p0_write, p0_waitrequest, p0_readdatavalid, p0_error;
    logic [ADDR_W-1:0] p0_address;
    logic [BE_W-1:0]   p0_byteenable;
    logic [DATA_W-1:0] p0_writedata, p0_readdata;
    logic              p1_chipselect, p1_write, p1_waitrequest, p1_readdatavalid, p1_error;
    logic [ADDR_W-1:0] p1_address;
    logic [BE_W-1:0]   p1_byteenable;
    logic [DATA_W-1:0] p1_writedata, p1_readdata;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic [DATA_W-1:0] mem_writedata, mem_readdata;
    logic              mem_chipselect, mem_write, mem_clken;

    onchip_memory_arbiter dut (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .p0_chipselect(p0_chipselect), .p0_write(p0_write), .p0_address(p0_address),
        .p0_byteenable(p0_byteenable), .p0_writedata(p0_writedata),
        .p0_waitrequest(p0_waitrequest), .p0_readdata(p0_readdata),
        .p0_readdatavalid(p0_readdatavalid), .p0_error(p0_error),
        .p1_chipselect(p1_chipselect), .p1_write(p1_write), .p1_address(p1_address),
        .p1_byteenable(p1_byteenable), .p1_writedata(p1_writedata),
        .p1_waitrequest(p1_waitrequest), .p1_readdata(p1_readdata),
        .p1_readdatavalid(p1_readdatavalid), .p1_error(p1_error),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM with clock enable
    logic [DATA_W-1:0] ram [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    typedef struct {
        bit                stall;
        bit                cs0;
        bit                wr0;
        logic [ADDR_W-1:0] a0;
        logic [BE_W-1:0]   be0;
        logic [DATA_W-1:0] d0;
        bit                cs1;
        bit                wr1;
        logic [ADDR_W-1:0] a1;
        logic [BE_W-1:0]   be1;
        logic [DATA_W-1:0] d1;
        int                gnt;   // -1 none, 0/1 that port, 2 tie resolved by the model
    } vec_t;

    typedef struct {
        int                port;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    vec_t              vecs[$];
    exp_t              sbq[$];
    logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                m_last = 0;
    int                err_due[2] = '{-1, -1};
    bit                m_cs = 1'b0;
    bit                m_wr = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [BE_W-1:0]   m_be = '0;
    logic [DATA_W-1:0] m_wd = '0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(bit st, bit c0, bit w0, int a0, int b0, logic [DATA_W-1:0] d0,
                                bit c1, bit w1, int a1, int b1, logic [DATA_W-1:0] d1, int g);
        vec_t v;
        v.stall = st;
        v.cs0 = c0; v.wr0 = w0; v.a0 = ADDR_W'(a0); v.be0 = BE_W'(b0); v.d0 = d0;
        v.cs1 = c1; v.wr1 = w1; v.a1 = ADDR_W'(a1); v.be1 = BE_W'(b1); v.d1 = d1;
        v.gnt = g;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    endfunction

    function automatic vec_t acc0(bit w, int a, int be, logic [DATA_W-1:0] d);
        return mk(0, 1, w, a, be, d, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t acc1(bit w, int a, int be, logic [DATA_W-1:0] d);
        return mk(0, 0, 0, 0, 0, 0, 1, w, a, be, d, 1);
    endfunction

    task automatic drive(input vec_t v);
        stall = v.stall;
        p0_chipselect = v.cs0; p0_write = v.wr0; p0_address = v.a0;
        p0_byteenable = v.be0; p0_writedata = v.d0;
        p1_chipselect = v.cs1; p1_write = v.wr1; p1_address = v.a1;
        p1_byteenable = v.be1; p1_writedata = v.d1;
    endtask

    // One clock cycle: drive, sample at negedge, compare against the model, advance the model
    task automatic run_vec(input vec_t v);
        exp_t              e;
        bit                hit;
        int                g;
        bit                w;
        bit                n_cs, n_wr;
        logic [ADDR_W-1:0] a, n_addr;
        logic [BE_W-1:0]   be, n_be;
        logic [DATA_W-1:0] d, n_wd;

        drive(v);
        @(negedge clk);
        cyc++;
        if (v.stall) begin
            for (int i = 0; i < sbq.size(); i++) sbq[i].due = sbq[i].due + 1;
        end

        chk("mem_clken", mem_clken, !v.stall);
        chk("mem_chipselect", mem_chipselect, m_cs);
        chk("mem_write", mem_write, m_cs && m_wr);
        if (m_cs) begin
            chk("mem_address", mem_address, m_addr);
            if (m_wr) begin
                chk("mem_byteenable", mem_byteenable, m_be);
                chk("mem_writedata", mem_writedata, m_wd);
            end
        end

        hit = (sbq.size() > 0) && (sbq[0].due == cyc);
        e = '{port: -1, data: '0, due: 0};
        if (hit) e = sbq.pop_front();
        chk("p0_readdatavalid", p0_readdatavalid, hit && e.port == 0);
        chk("p1_readdatavalid", p1_readdatavalid, hit && e.port == 1);
        chk("p0_readdata", p0_readdata, (hit && e.port == 0) ? e.data : '0);
        chk("p1_readdata", p1_readdata, (hit && e.port == 1) ? e.data : '0);
        chk("p0_error", p0_error, err_due[0] == cyc);
        chk("p1_error", p1_error, err_due[1] == cyc);

        g = v.gnt;
        if (g == 2) g = (RR && m_last == 0) ? 1 : 0;
        chk("p0_waitrequest", p0_waitrequest, g != 0);
        chk("p1_waitrequest", p1_waitrequest, g != 1);

        n_cs = 1'b0; n_wr = 1'b0; n_addr = m_addr; n_be = m_be; n_wd = m_wd;
        if (g >= 0) begin
            if (g == 0) begin w = v.wr0; a = v.a0; be = v.be0; d = v.d0; end
            else        begin w = v.wr1; a = v.a1; be = v.be1; d = v.d1; end
            m_last = g;
            if (32'(a) >= DEPTH) begin
                err_due[g] = cyc + 1;
            end else begin
                n_cs = 1'b1; n_wr = w; n_addr = a; n_be = be; n_wd = d;
                if (w) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
                    end
                end else begin
                    e.port = g; e.data = ref_mem[a]; e.due = cyc + 2;
                    sbq.push_back(e);
                end
            end
        end
        if (!v.stall) begin
            m_cs = n_cs; m_wr = n_wr; m_addr = n_addr; m_be = n_be; m_wd = n_wd;
        end
        @(posedge clk);
        #1;
    endtask

    // Hold reset with both ports requesting; everything except waitrequest must read 0
    task automatic reset_cycles(input int n);
        reset_n = 1'b0;
        drive(mk(0, 1, 0, 'h10, 'hF, 0, 1, 0, 'h20, 'hF, 0, -1));
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            chk("rst p0_waitrequest", p0_waitrequest, 1);
            chk("rst p1_waitrequest", p1_waitrequest, 1);
            chk("rst mem_chipselect", mem_chipselect, 0);
            chk("rst mem_write", mem_write, 0);
            chk("rst mem_clken", mem_clken, 0);
            chk("rst mem_address", mem_address, 0);
            chk("rst p0_readdatavalid", p0_readdatavalid, 0);
            chk("rst p1_readdatavalid", p1_readdatavalid, 0);
            chk("rst p0_readdata", p0_readdata, 0);
            chk("rst p1_readdata", p1_readdata, 0);
            chk("rst p0_error", p0_error, 0);
            chk("rst p1_error", p1_error, 0);
            @(posedge clk);
            #1;
        end
        sbq.delete();
        err_due = '{-1, -1};
        m_cs = 1'b0; m_wr = 1'b0; m_addr = '0; m_be = '0; m_wd = '0;
        m_last = 0;
        drive(idle());
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // Write then read back, port 0 only
        vecs.push_back(acc0(1, 'h10, 'hF, 32'hDEADBEEF));
        vecs.push_back(acc0(0, 'h10, 'hF, 0));
        vecs.push_back(idle()); vecs.push_back(idle());
        // Partial byte-enable write merges into existing word
        vecs.push_back(acc1(1, 'h20, 'hF, 32'hFFFFFFFF));
        vecs.push_back(acc1(1, 'h20, 'h3, 32'h00001234));
        vecs.push_back(acc1(0, 'h20, 'hF, 0));
        vecs.push_back(idle()); vecs.push_back(idle());
        // Both ports reading continuously
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 0, 'h10, 'hF, 0, 1, 0, 'h20, 'hF, 0, 2));
        vecs.push_back(acc1(0, 'h20, 'hF, 0));
        vecs.push_back(idle()); vecs.push_back(idle());
        // Three-cycle stall right after a read is accepted; p1 requests during the stall
        vecs.push_back(acc0(0, 'h20, 'hF, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 'h10, 'hF, 0, -1));
        vecs.push_back(idle()); vecs.push_back(idle()); vecs.push_back(idle());
        // Back-to-back reads with a stall landing on the first return cycle
        vecs.push_back(acc0(0, 'h10, 'hF, 0));
        vecs.push_back(acc1(0, 'h20, 'hF, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
        vecs.push_back(idle()); vecs.push_back(idle()); vecs.push_back(idle());
        // Out-of-range requests and the last valid word
        vecs.push_back(acc1(0, 5120, 'hF, 0));
        vecs.push_back(idle()); vecs.push_back(idle());
        vecs.push_back(acc0(1, 8191, 'hF, 32'h0BADF00D));
        vecs.push_back(idle());
        vecs.push_back(acc0(1, 5119, 'hF, 32'hA5A55A5A));
        vecs.push_back(acc1(0, 5119, 'hF, 0));
        vecs.push_back(idle()); vecs.push_back(idle());
        // Write immediately followed by read of the same word
        vecs.push_back(acc0(1, 'h30, 'hF, 32'h11223344));
        vecs.push_back(acc0(0, 'h30, 'hF, 0));
        vecs.push_back(idle()); vecs.push_back(idle());

        reset_n = 1'b0;
        drive(idle());
        reset_cycles(3);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the cycle after a read is accepted: the read must never return
        run_vec(acc0(0, 'h10, 'hF, 0));
        reset_cycles(2);
        for (int i = 0; i < 3; i++) run_vec(idle());
        // Pointer is back at port 0 after reset
        run_vec(mk(0, 1, 0, 'h10, 'hF, 0, 1, 0, 'h20, 'hF, 0, 2));
        for (int i = 0; i < 3; i++) run_vec(idle());

        chk("scoreboard drained", 32'(sbq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/onchip_memory_arbiter.md
# onchip_memory_arbiter

Two-port Avalon-MM arbiter that shares the single-port 5120x32 on-chip RAM between two requesters, e.g. the Nios data master and the PLL reconfiguration DMA. It accepts at most one access per cycle, drives the RAM's address, byteenable, chipselect, write and clock-enable pins, and tracks the RAM's one-cycle read latency. Read data is returned to the requester that issued the read. A stall input freezes the RAM pipeline without losing commands or read data.

## Interface
Parameters:
- ADDR_W, 13, word address width
- DATA_W, 32, data width
- DEPTH, 5120, valid words; addresses >= DEPTH are rejected

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  freeze request; RAM clock enable is deasserted while high
- pN_chipselect  in  1  request valid, port N (N = 0,1)
- pN_write  in  1  1 = write, 0 = read
- pN_address  in  ADDR_W  word address
- pN_byteenable  in  DATA_W/8  byte lanes
- pN_writedata  in  DATA_W  write data
- pN_waitrequest  out  1  high = request not accepted this cycle
- pN_readdata  out  DATA_W  read data
- pN_readdatavalid  out  1  one-cycle strobe for pN_readdata
- pN_error  out  1  one-cycle strobe: out-of-range request was dropped
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  DATA_W/8  RAM byte enables
- mem_writedata  out  DATA_W  RAM write data
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write
- mem_clken  out  1  RAM clock enable
- mem_readdata  in  DATA_W  RAM q, unregistered

## Operation
- Command register: holds one issued access, with fields {valid, write, owner, addr, be, wdata}. It drives the mem_* outputs. When not valid, mem_chipselect=0 and mem_write=0.
- Acceptance: when stall=0, the arbiter picks one requesting port. The picked port sees waitrequest=0 and its request loads the command register at the clock edge.
- Waitrequest: the non-picked port sees waitrequest=1. When stall=1, both ports see waitrequest=1.
- Out-of-range requests (address >= DEPTH): accepted (waitrequest=0) but not issued. pN_error pulses in the next cycle.
- Read return: the owner of an issued read is pushed into a one-entry return tag. In the cycle after the command, that owner's readdatavalid=1 and its readdata=mem_readdata. The other port's readdata is held at 0.
- Stall: mem_clken = ~stall. The command register, return tag and arbitration pointer all hold. readdatavalid is suppressed while stalled and is reasserted when stall falls, so no read is lost or duplicated.
- Simultaneous requests are resolved per Configuration.
- Reset: all outputs are 0 except pN_waitrequest, which is 1. The command register and return tag are cleared, and the pointer is reset to port 0.
- Reset mid-read: the pending read is dropped and never returns a valid strobe.

## Timing
- Accept in cycle N → mem_chipselect in cycle N+1 → pN_readdatavalid in cycle N+2.
- Throughput: one access per cycle, reads and writes can be back-to-back.
- A write completes at the end of cycle N+1.
- A stall lasting S cycles adds exactly S cycles to every in-flight latency.
- Error strobe: asserted in cycle N+1.
- No combinational path from mem_readdata to any waitrequest.

## Configuration
- ONCHIP_ARB_RR_EN defined: round-robin arbitration. A 1-bit last-grant pointer is updated on each accept, and on a tie the port not granted last wins.
- ONCHIP_ARB_RR_EN undefined: fixed priority, port 0 always wins ties. The pointer logic is not built.

## Structure
- Package onchip_arb_pkg holds:
  - ADDR_W, DATA_W and DEPTH defaults
  - the port_id_t typedef (1 bit)
  - the cmd_t struct {valid, write, owner, addr, be, wdata}
- Sub-module onchip_arb_pick: takes the two request bits and the last-grant pointer, and returns grant and the next pointer. It holds the only code that changes with ONCHIP_ARB_RR_EN.

## Test plan
- Port 0 writes 0xDEADBEEF to address 0x0010 with be=0xF, then reads 0x0010 → p0_readdatavalid 2 cycles after accept, p0_readdata=0xDEADBEEF; p1 sees no strobe.
- Both ports read continuously, RR enabled → grants alternate 0,1,0,1; each port gets its own data, one access per cycle. RR disabled → port 1 waits until port 0 drops chipselect.
- Write to 0x0020 with be=0x3 over 0xFFFFFFFF → read returns 0xFFFF1234 when writedata=0x00001234.
- Read accepted, stall=1 for 3 cycles in cycle N+1 → mem_clken=0 during the stall; readdatavalid arrives at N+5 with correct data, exactly once.
- p1 reads address 5120 → accepted, mem_chipselect stays 0, p1_error pulses once, no readdatavalid.
- reset_n asserted in the cycle after a read is accepted → no readdatavalid after release; all waitrequests are 1 during reset.
